// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set
//   LEDs, 0xFF reset) to the attached keyboard over the shared open-drain
//   ps2_clk / ps2_data lines. Lives in the clk_usb domain next to the PS/2
//   receiver, which uses `busy` to ignore line activity while we transmit.
//
// Ports
//   clk          system clock (48 MHz clk_usb)
//   reset        asynchronous, active-high reset; releases both lines at once
//   data         command byte, sampled when valid && ready
//   valid        command byte valid
//   ready        high only in IDLE
//   busy         high in every state except IDLE
//   done         one-cycle pulse: byte acknowledged by the device
//   error        one-cycle pulse: NACK or timeout
//   ps2_clk_in   raw level of the ps2_clk pin (asynchronous)
//   ps2_data_in  raw level of the ps2_data pin (asynchronous)
//   ps2_clk_oe   1 = pull ps2_clk low, 0 = release
//   ps2_data_oe  1 = pull ps2_data low, 0 = release
//
// States
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   S_IDLE      | lines released, waiting for a command byte
//   S_INHIBIT   | clock held low to stop the device from transmitting
//   S_REQUEST   | clock and data low (start bit), request-to-send setup
//   S_SHIFT     | clock released, next bit presented on each device fall
//   S_ACK       | stop bit sent, sample the device ack on the next fall
//   S_WAIT_IDLE | ack seen, wait for both lines to return high

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned SETUP_CYCLES   = 48,
    parameter int unsigned TIMEOUT_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
    localparam int SW = $clog2(SETUP_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQUEST,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic          clk_meta_q, clk_sync_q, clk_prev_q;
    logic          data_meta_q, data_sync_q;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [3:0]    idx_q, idx_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [SW-1:0] set_q, set_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          fall;

    // Synchronised falling edge of the device clock; no glitch filtering.
    assign fall = clk_prev_q & ~clk_sync_q;

    // State and datapath registers. Synchronisers reset to the idle-high level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            sh_q        <= '0;
            par_q       <= 1'b0;
            idx_q       <= '0;
            inh_q       <= '0;
            set_q       <= '0;
            tmo_q       <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
            sh_q        <= sh_d;
            par_q       <= par_d;
            idx_q       <= idx_d;
            inh_q       <= inh_d;
            set_q       <= set_d;
            tmo_q       <= tmo_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        par_d     = par_q;
        idx_d     = idx_q;
        inh_d     = inh_q;
        set_d     = set_q;
        tmo_d     = tmo_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (valid) begin
                    sh_d     = data;
                    par_d    = ~^data;
                    inh_d    = IW'(INHIBIT_CYCLES - 1);
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (inh_q == '0) begin
                    data_oe_d = 1'b1;
                    set_d     = SW'(SETUP_CYCLES - 1);
                    state_d   = S_REQUEST;
                end else begin
                    inh_d = inh_q - 1'b1;
                end
            end

            S_REQUEST: begin
                if (set_q == '0) begin
                    clk_oe_d = 1'b0;
                    tmo_d    = TW'(TIMEOUT_CYCLES - 1);
                    idx_d    = '0;
                    state_d  = S_SHIFT;
                end else begin
                    set_d = set_q - 1'b1;
                end
            end

            S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                // Terminal count of the whole-transfer timer wins over any
                // line event in the same cycle.
                if (tmo_q == '0) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                    if (state_q == S_SHIFT) begin
                        if (fall) begin
                            idx_d = idx_q + 4'd1;
                            if (idx_q < 4'd8) begin
                                data_oe_d = ~sh_q[0];
                                sh_d      = {1'b0, sh_q[7:1]};
                            end else if (idx_q == 4'd8) begin
                                data_oe_d = ~par_q;
                            end else begin
                                data_oe_d = 1'b0;
                                state_d   = S_ACK;
                            end
                        end
                    end else if (state_q == S_ACK) begin
                        if (fall) begin
                            if (!data_sync_q) begin
                                state_d = S_WAIT_IDLE;
                            end else begin
                                error_d = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                    end else begin
                        if (clk_sync_q && data_sync_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        ready       = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        done        = done_q;
        error       = error_q;
        ps2_clk_oe  = clk_oe_q;
        ps2_data_oe = data_oe_q;
    end

endmodule
